// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code set 2 decoder driving held-key levels
// for the W/S/O/L paddle controls, all in the iVGA_CLK domain.
module ps2_key_decoder #(
    parameter int          FILTER_LEN     = 8,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  KEY_W          = 8'h1D,
    parameter logic [7:0]  KEY_S          = 8'h1B,
    parameter logic [7:0]  KEY_O          = 8'h44,
    parameter logic [7:0]  KEY_L          = 8'h4B
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       w_in,
    output logic       s_in,
    output logic       o_in,
    output logic       l_in,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic             filt_q, filt_d;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic             fe;

    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             brk_q, brk_d, ext_q, ext_d;
    logic             w_q, w_d, s_q, s_d, o_q, o_d, l_q, l_d;
    logic [7:0]       code_q, code_d;
    logic             valid_q, valid_d, err_q, err_d;

    // Filtered clock flips only after FILTER_LEN consecutive opposite samples.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1))
                filt_d = clk_s2_q;
            else
                flt_cnt_d = flt_cnt_q + 1'b1;
        end
    end

    assign fe = filt_q & ~filt_d;

    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_d     = '0;
        brk_d     = brk_q;
        ext_d     = ext_q;
        w_d       = w_q;
        s_d       = s_q;
        o_d       = o_q;
        l_d       = l_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        if (state_q != IDLE && !fe) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                err_d   = 1'b1;
                brk_d   = 1'b0;
                ext_d   = 1'b0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        if (fe) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    parity_d = dat_s2_q;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat_s2_q && (^shift_q ^ parity_q)) begin
                        code_d  = shift_q;
                        valid_d = 1'b1;
                        if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else begin
                            if (!ext_q) begin
                                if (shift_q == KEY_W) w_d = ~brk_q;
                                if (shift_q == KEY_S) s_d = ~brk_q;
                                if (shift_q == KEY_O) o_d = ~brk_q;
                                if (shift_q == KEY_L) l_d = ~brk_q;
                            end
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            w_q       <= 1'b0;
            s_q       <= 1'b0;
            o_q       <= 1'b0;
            l_q       <= 1'b0;
            code_q    <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            dat_s1_q  <= ps2_data;
            dat_s2_q  <= dat_s1_q;
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tmo_q     <= tmo_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            w_q       <= w_d;
            s_q       <= s_d;
            o_q       <= o_d;
            l_q       <= l_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign w_in       = w_q;
    assign s_in       = s_q;
    assign o_in       = o_q;
    assign l_in       = l_q;
    assign scan_code  = code_q;
    assign scan_valid = valid_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of frames with expected key
// levels, plus timeout, clock-glitch and mid-frame reset sequences.
module tb_ps2_key_decoder;

    localparam int HALF    = 40;
    localparam int TIMEOUT = 2000;

    typedef struct {
        logic [7:0] data;
        bit         par_ok;
        bit         stop;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_code;
        logic [3:0] exp_keys;   // {w, s, o, l}
    } vec_t;

    logic       iVGA_CLK = 1'b0;
    logic       iRST_n   = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       w_in, s_in, o_in, l_in, scan_valid, frame_err;
    logic [7:0] scan_code;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    logic valid_prev = 1'b0;
    logic err_prev = 1'b0;

    vec_t vecs [22];

    ps2_key_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .iVGA_CLK  (iVGA_CLK),
        .iRST_n    (iRST_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .w_in      (w_in),
        .s_in      (s_in),
        .o_in      (o_in),
        .l_in      (l_in),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .frame_err (frame_err)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse monitor: single-cycle width and mutual exclusion.
    always @(negedge iVGA_CLK) begin
        if (iRST_n) begin
            if (scan_valid) valid_cnt++;
            if (frame_err)  err_cnt++;
            if (scan_valid || frame_err)
                check("pulse_shape",
                      {30'd0, scan_valid & frame_err,
                       (scan_valid & valid_prev) | (frame_err & err_prev)}, 32'd0);
        end
        valid_prev = scan_valid;
        err_prev   = frame_err;
    end

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(posedge iVGA_CLK);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge iVGA_CLK);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit par_ok, input bit stop);
        logic par;
        par = par_ok ? ~^d : ^d;
        return {stop, par, d, 1'b0};
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] d, input bit par_ok,
                             input bit stop, input int ev, input int ee,
                             input logic [7:0] ecode, input logic [3:0] ekeys);
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(frame_bits(d, par_ok, stop), 11);
        ps2_data = 1'b1;
        repeat (60) @(posedge iVGA_CLK);
        @(negedge iVGA_CLK);
        check({tag, " valid_count"}, valid_cnt - v0, ev);
        check({tag, " err_count"},   err_cnt - e0,   ee);
        check({tag, " scan_code"},   {24'd0, scan_code}, {24'd0, ecode});
        check({tag, " keys"},        {28'd0, w_in, s_in, o_in, l_in}, {28'd0, ekeys});
    endtask

    initial begin
        int v0, e0, waited;

        vecs = '{
            '{8'h1D, 1, 1, 1, 0, 8'h1D, 4'b1000},   // make W
            '{8'hF0, 1, 1, 1, 0, 8'hF0, 4'b1000},
            '{8'h1D, 1, 1, 1, 0, 8'h1D, 4'b0000},   // break W
            '{8'h1B, 1, 1, 1, 0, 8'h1B, 4'b0100},
            '{8'h44, 1, 1, 1, 0, 8'h44, 4'b0110},   // S and O held together
            '{8'hF0, 1, 1, 1, 0, 8'hF0, 4'b0110},
            '{8'h1B, 1, 1, 1, 0, 8'h1B, 4'b0010},
            '{8'h4B, 0, 1, 0, 1, 8'h1B, 4'b0010},   // parity error
            '{8'hE0, 1, 1, 1, 0, 8'hE0, 4'b0010},
            '{8'h4B, 1, 1, 1, 0, 8'h4B, 4'b0010},   // extended, ignored
            '{8'h44, 1, 1, 1, 0, 8'h44, 4'b0010},   // typematic repeat
            '{8'hF0, 1, 1, 1, 0, 8'hF0, 4'b0010},
            '{8'h4B, 1, 1, 1, 0, 8'h4B, 4'b0010},   // break of unheld key
            '{8'h4B, 1, 1, 1, 0, 8'h4B, 4'b0011},
            '{8'hF0, 1, 1, 1, 0, 8'hF0, 4'b0011},
            '{8'h4B, 1, 1, 1, 0, 8'h4B, 4'b0010},
            '{8'hF0, 1, 1, 1, 0, 8'hF0, 4'b0010},
            '{8'h1D, 0, 1, 0, 1, 8'hF0, 4'b0010},   // error clears break flag
            '{8'h1D, 1, 1, 1, 0, 8'h1D, 4'b1010},
            '{8'h44, 1, 0, 0, 1, 8'h1D, 4'b1010},   // bad stop bit
            '{8'hF0, 1, 1, 1, 0, 8'hF0, 4'b1010},
            '{8'h44, 1, 1, 1, 0, 8'h44, 4'b1000}
        };

        repeat (5) @(posedge iVGA_CLK);
        @(negedge iVGA_CLK);
        check("reset outputs", {20'd0, w_in, s_in, o_in, l_in, scan_code},
              32'd0);
        check("reset pulses", {30'd0, scan_valid, frame_err}, 32'd0);
        iRST_n = 1'b1;
        repeat (20) @(posedge iVGA_CLK);

        for (int i = 0; i < 22; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par_ok, vecs[i].stop,
                      vecs[i].exp_valid, vecs[i].exp_err, vecs[i].exp_code, vecs[i].exp_keys);

        // Truncated frame: start + 5 data bits, then silence until timeout.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(frame_bits(8'h44, 1, 1), 6);
        ps2_data = 1'b1;
        waited = 0;
        while (err_cnt == e0 && waited < TIMEOUT + 200) begin
            @(posedge iVGA_CLK);
            waited++;
        end
        repeat (5) @(posedge iVGA_CLK);
        @(negedge iVGA_CLK);
        check("timeout err_count",   err_cnt - e0,   1);
        check("timeout valid_count", valid_cnt - v0, 0);
        run_frame("after_timeout", 8'h44, 1, 1, 1, 0, 8'h44, 4'b1010);

        // Short low glitch with data low: a false edge would start a frame.
        v0 = valid_cnt;
        e0 = err_cnt;
        ps2_data = 1'b0;
        @(posedge iVGA_CLK);
        ps2_clk = 1'b0;
        repeat (3) @(posedge iVGA_CLK);
        ps2_clk = 1'b1;
        repeat (50) @(posedge iVGA_CLK);
        ps2_data = 1'b1;
        repeat (50) @(posedge iVGA_CLK);
        check("glitch pulses", (valid_cnt - v0) + (err_cnt - e0), 0);
        run_frame("after_glitch", 8'h1B, 1, 1, 1, 0, 8'h1B, 4'b1110);

        // Reset in the middle of a frame while W is held.
        send_bits(frame_bits(8'h1D, 1, 1), 5);
        #3;
        iRST_n = 1'b0;
        #1;
        check("midframe reset outputs",
              {20'd0, w_in, s_in, o_in, l_in, scan_code}, 32'd0);
        check("midframe reset pulses", {30'd0, scan_valid, frame_err}, 32'd0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge iVGA_CLK);
        @(negedge iVGA_CLK);
        iRST_n = 1'b1;
        repeat (20) @(posedge iVGA_CLK);
        run_frame("after_reset", 8'h1D, 1, 1, 1, 0, 8'h1D, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
